// File: rtl/clock_mode_controller.sv
// clock_mode_controller: run/set mode FSM, hh:mm:ss timekeeping, alarm registers and ring timer; ports: clk, rst, tick, btn_mode/btn_inc/btn_alarm in; time, alarm, mode, alarm_armed, alarm_ring out
module clock_mode_controller #(
  parameter int RING_SECONDS  = 60,
  parameter int ALARM_RST_HR  = 6,
  parameter int ALARM_RST_MIN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [2:0] mode,
  output logic       alarm_armed,
  output logic       alarm_ring
);
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } state_t;
  state_t state, state_n;
  logic [7:0] ring_cnt, ring_cnt_n;
  logic [4:0] hr_n, ahr_n;
  logic [5:0] min_n, sec_n, amin_n;
  logic silence, adv, inc, count, sec_wrap, min_wrap, hit, ring_n;
  assign silence  = alarm_ring & (btn_mode | btn_inc | btn_alarm);
  assign adv      = btn_mode & ~silence;
  assign inc      = btn_inc & ~btn_mode & ~alarm_ring;
  // leaving RUN clears seconds, so a tick in that cycle is dropped
  assign count    = tick & ((state == RUN & ~adv) | state == SET_AHR | state == SET_AMIN);
  assign sec_wrap = count & seconds == 6'd59;
  assign min_wrap = sec_wrap & minutes == 6'd59;
  assign sec_n    = (adv & state == RUN) ? 6'd0 : count ? (sec_wrap ? 6'd0 : seconds + 6'd1) : seconds;
  assign min_n    = (sec_wrap | (inc & state == SET_MIN)) ? (minutes == 6'd59 ? 6'd0 : minutes + 6'd1) : minutes;
  assign hr_n     = (min_wrap | (inc & state == SET_HR)) ? (hours == 5'd23 ? 5'd0 : hours + 5'd1) : hours;
  assign ahr_n    = (inc & state == SET_AHR) ? (alarm_hours == 5'd23 ? 5'd0 : alarm_hours + 5'd1) : alarm_hours;
  assign amin_n   = (inc & state == SET_AMIN) ? (alarm_minutes == 6'd59 ? 6'd0 : alarm_minutes + 6'd1) : alarm_minutes;
  // only a tick that lands exactly on hh:mm:00 can start the ring
  assign hit        = count & alarm_armed & ~alarm_ring & sec_n == 6'd0 & min_n == alarm_minutes & hr_n == alarm_hours;
  assign ring_n     = silence ? 1'b0 : hit ? 1'b1 : (alarm_ring & tick & ring_cnt == 8'd1) ? 1'b0 : alarm_ring;
  assign ring_cnt_n = silence ? 8'd0 : hit ? 8'(RING_SECONDS) : (alarm_ring & tick) ? ring_cnt - 8'd1 : ring_cnt;
  assign mode       = state;
  always_comb begin
    state_n = state;
    case (state)
      RUN:      state_n = adv ? SET_HR : RUN;
      SET_HR:   state_n = adv ? SET_MIN : SET_HR;
      SET_MIN:  state_n = adv ? SET_AHR : SET_MIN;
      SET_AHR:  state_n = adv ? SET_AMIN : SET_AHR;
      SET_AMIN: state_n = adv ? RUN : SET_AMIN;
      default:  state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hours         <= 5'd0;
      minutes       <= 6'd0;
      seconds       <= 6'd0;
      alarm_hours   <= 5'(ALARM_RST_HR);
      alarm_minutes <= 6'(ALARM_RST_MIN);
      alarm_armed   <= 1'b0;
      alarm_ring    <= 1'b0;
      ring_cnt      <= 8'd0;
    end else begin
      hours         <= hr_n;
      minutes       <= min_n;
      seconds       <= sec_n;
      alarm_hours   <= ahr_n;
      alarm_minutes <= amin_n;
      alarm_armed   <= alarm_armed ^ btn_alarm;
      alarm_ring    <= ring_n;
      ring_cnt      <= ring_cnt_n;
    end
  end
endmodule

// File: tb/tb_clock_mode_controller.sv
// tb_clock_mode_controller: scoreboard bench for clock_mode_controller against a seconds-of-day reference model
module tb_clock_mode_controller;
  localparam int RING = 60;
  typedef logic [32:0] vec_t;
  logic clk = 0, rst = 0, tick = 0, btn_mode = 0, btn_inc = 0, btn_alarm = 0;
  logic [4:0] hours, alarm_hours;
  logic [5:0] minutes, seconds, alarm_minutes;
  logic [2:0] mode;
  logic alarm_armed, alarm_ring;
  vec_t dut_vec, exp_q[$];
  int applied = 0, miscompares = 0;
  int m_h, m_m, m_s, m_ah, m_am, m_mode, m_cnt;
  bit m_armed, m_ring;
  clock_mode_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
    .hours(hours), .minutes(minutes), .seconds(seconds), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .mode(mode), .alarm_armed(alarm_armed), .alarm_ring(alarm_ring)
  );
  assign dut_vec = {hours, minutes, seconds, alarm_hours, alarm_minutes, mode, alarm_armed, alarm_ring};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic vec_t pack_model();
    return {5'(m_h), 6'(m_m), 6'(m_s), 5'(m_ah), 6'(m_am), 3'(m_mode), m_armed, m_ring};
  endfunction
  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_ah = 6; m_am = 0;
    m_mode = 0; m_cnt = 0; m_armed = 0; m_ring = 0;
  endtask
  task automatic model_step(input bit t, input bit bm, input bit bi, input bit ba);
    bit sil, cnt_en, trig;
    int tod;
    sil = m_ring && (bm || bi || ba);
    cnt_en = t && (m_mode == 0 || m_mode >= 3);
    trig = 0;
    if (bm && !sil && m_mode == 0) begin
      cnt_en = 0;
      m_s = 0;
    end
    if (cnt_en) begin
      tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = tod / 3600;
      m_m = (tod / 60) % 60;
      m_s = tod % 60;
      trig = m_armed && !m_ring && m_s == 0 && m_m == m_am && m_h == m_ah;
    end
    if (bm && !sil) m_mode = (m_mode + 1) % 5;
    else if (bi && !sil) begin
      if (m_mode == 1) m_h = (m_h + 1) % 24;
      if (m_mode == 2) m_m = (m_m + 1) % 60;
      if (m_mode == 3) m_ah = (m_ah + 1) % 24;
      if (m_mode == 4) m_am = (m_am + 1) % 60;
    end
    if (ba) m_armed = !m_armed;
    if (sil) begin
      m_ring = 0;
      m_cnt = 0;
    end else if (trig) begin
      m_ring = 1;
      m_cnt = RING;
    end else if (m_ring && t) begin
      m_cnt--;
      if (m_cnt == 0) m_ring = 0;
    end
  endtask
  task automatic step(input bit t, input bit bm, input bit bi, input bit ba);
    @(negedge clk);
    tick = t; btn_mode = bm; btn_inc = bi; btn_alarm = ba;
    model_step(t, bm, bi, ba);
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    tick = 0; btn_mode = 0; btn_inc = 0; btn_alarm = 0;
    check("cycle", dut_vec, exp_q.pop_front());
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1;
    model_reset();
    exp_q.push_back(pack_model());
    #1;
    check("async_rst", dut_vec, exp_q.pop_front());
    @(negedge clk);
    rst = 0;
  endtask
  task automatic setup_alarm(input int mins);
    do_reset();
    repeat (3) step(0, 1, 0, 0);
    repeat (18) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (mins) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("alarm_setup", {alarm_hours, alarm_minutes, mode, alarm_armed}, {5'd0, 6'(mins), 3'd0, 1'b1});
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    ticks(3661);
    check("t3661", {hours, minutes, seconds}, {5'd1, 6'd1, 6'd1});
    step(0, 1, 0, 0);
    check("enter_sethr", {mode, seconds}, {3'd1, 6'd0});
    repeat (3) step(1, 0, 0, 0);
    check("frozen_hr", {hours, minutes, seconds}, {5'd1, 6'd1, 6'd0});
    repeat (22) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    check("inc_mode_same", {mode, hours}, {3'd2, 5'd23});
    step(0, 0, 1, 0);
    check("min_inc_only", {hours, minutes}, {5'd23, 6'd2});
    repeat (57) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("tick_leave_min", {mode, minutes, seconds}, {3'd3, 6'd59, 6'd0});
    repeat (2) step(0, 1, 0, 0);
    check("set_2359", {mode, hours, minutes, seconds}, {3'd0, 5'd23, 6'd59, 6'd0});
    step(0, 0, 1, 0);
    check("inc_run_ignored", {hours, minutes}, {5'd23, 6'd59});
    ticks(60);
    check("midnight", {hours, minutes, seconds}, {5'd0, 6'd0, 6'd0});
    setup_alarm(2);
    ticks(119);
    check("pre_ring", alarm_ring, 1'b0);
    step(1, 0, 0, 0);
    check("ring_start", alarm_ring, 1'b1);
    step(0, 0, 0, 0);
    repeat (59) step(1, 0, 0, 0);
    check("ring_hold", alarm_ring, 1'b1);
    step(1, 0, 0, 0);
    check("ring_end", {alarm_ring, hours, minutes, seconds}, {1'b0, 5'd0, 6'd3, 6'd0});
    setup_alarm(2);
    ticks(120);
    check("ring2", alarm_ring, 1'b1);
    step(0, 0, 1, 0);
    check("silence_inc", {alarm_ring, minutes, mode, alarm_hours, alarm_minutes, alarm_armed},
          {1'b0, 6'd2, 3'd0, 5'd0, 6'd2, 1'b1});
    setup_alarm(2);
    ticks(120);
    step(0, 0, 0, 1);
    check("silence_alarm", {alarm_ring, alarm_armed}, {1'b0, 1'b0});
    setup_alarm(1);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("edit_no_ring", {alarm_ring, alarm_hours}, {1'b0, 5'd1});
    repeat (23) step(0, 0, 1, 0);
    ticks(60);
    check("ring_setahr", {mode, alarm_ring}, {3'd3, 1'b1});
    do_reset();
    check("rst_outputs", dut_vec, {5'd0, 6'd0, 6'd0, 5'd6, 6'd0, 3'd0, 1'b0, 1'b0});
    step(1, 0, 0, 0);
    check("post_rst_tick", seconds, 6'd1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Mode and timekeeping controller for the digital clock.
- Consumes the 1 Hz single-cycle tick from the divider stage and debounced single-cycle button pulses.
- Sequences the run and set modes, owns the hh:mm:ss time registers, alarm registers and alarm ring timer, and drives the display/alarm datapath.
- All logic is in the single clk domain.

Parameters:
- RING_SECONDS, 60, number of ticks alarm_ring stays asserted once triggered (1..255).
- ALARM_RST_HR, 6, alarm hour after reset (0..23).
- ALARM_RST_MIN, 0, alarm minute after reset (0..59).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  1 Hz enable, one clk cycle wide, synchronous to clk
- btn_mode  in  1  debounced press pulse, one cycle
- btn_inc  in  1  debounced press pulse, one cycle
- btn_alarm  in  1  debounced press pulse, one cycle; toggles alarm arm
- hours  out  5  current hour 0..23
- minutes  out  6  current minute 0..59
- seconds  out  6  current second 0..59
- alarm_hours  out  5  alarm hour 0..23
- alarm_minutes  out  6  alarm minute 0..59
- mode  out  3  FSM state encoding (for display field highlight)
- alarm_armed  out  1  alarm enabled
- alarm_ring  out  1  alarm sounding

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - time 00:00:00; alarm ALARM_RST_HR:ALARM_RST_MIN.
  - mode = RUN; alarm_armed = 0; alarm_ring = 0; ring counter = 0.
- All outputs are registered; every effect appears one clk after the causing input cycle.
- FSM states and encodings: RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4; encodings 5..7 are illegal and recover to RUN.
- btn_mode advances RUN->SET_HR->SET_MIN->SET_AHR->SET_AMIN->RUN.
- On the RUN->SET_HR transition, seconds are cleared to 0.
- Time counting:
  - On tick in RUN, SET_AHR or SET_AMIN: seconds+1.
  - seconds 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0.
  - In SET_HR and SET_MIN, tick is ignored: time is frozen.
- btn_inc behaviour by state:
  - SET_HR: hours+1, 23->0.
  - SET_MIN: minutes+1, 59->0.
  - SET_AHR: alarm_hours+1, 23->0.
  - SET_AMIN: alarm_minutes+1, 59->0.
  - No carry between fields when editing. Ignored in RUN.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode advances, inc is discarded.
  - tick and btn_inc in the same cycle in SET_AHR/SET_AMIN: both apply.
  - tick in the same cycle as btn_mode leaving SET_MIN: tick is ignored.
- btn_alarm: toggles alarm_armed in any state.
- Alarm trigger:
  - Condition: alarm_armed=1 and a tick advances time to exactly alarm_hours:alarm_minutes:00.
  - Result: alarm_ring=1 in the same cycle the new time appears; the ring counter loads RING_SECONDS.
- While ringing:
  - Each tick decrements the ring counter; when it reaches 0, alarm_ring deasserts with that tick's update.
  - Time continues counting during the ring.
- Silencing while alarm_ring=1:
  - Any btn_mode or btn_inc press clears alarm_ring and is consumed, with no mode change and no increment.
  - btn_alarm clears alarm_ring and also toggles armed (disarms).
- Retrigger: while already ringing, a new match has no effect.
- Editing alarm fields: an alarm-field edit never triggers a ring by itself; only a tick-driven time match does.

Test Plan:
- Reset, then 3661 ticks -> hours=1, minutes=1, seconds=1; no output changes on non-tick cycles.
- Set the time to 23:59 via SET_HR (23 inc presses) and SET_MIN (59 presses), mode x4 back to RUN, then 60 ticks -> 00:00:00. Seconds read 0 on entering SET_HR, and ticks issued while in SET_HR/SET_MIN leave time unchanged.
- In SET_HR with hours=23, pulse btn_inc and btn_mode in the same cycle -> mode=2, hours=23. Then btn_inc -> minutes+1 only.
- Alarm set to 00:02, armed, time 00:00:00, RUN, 120 ticks -> alarm_ring=1 one clk after the 120th tick. After 60 more ticks -> alarm_ring=0 one clk after the 180th.
- During a ring, pulse btn_inc -> alarm_ring=0 next clk; minutes, mode and alarm fields unchanged. Repeat with btn_alarm -> ring=0, armed=0.
- Assert rst mid-ring in SET_AHR -> all outputs return to reset values immediately, without waiting for a clk edge. After rst is released, the next tick -> seconds=1.
